binning_kxk: RTL



---
 rtl/binning_kxk.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/binning_kxk.sv
// Streaming KxK pixel binner: per-bin column accumulators fold each KxK block
// into one sum, then a mode-selected decision bit is emitted one cycle later.
module binning_kxk #(
  parameter int  HRES        = 1280,
  parameter int  VRES        = 720,
  parameter int  DATA_WIDTH  = 1,
  parameter int  KERNEL_LOG2 = 2,
  localparam int K           = 2 ** KERNEL_LOG2,
  localparam int HWIDTH      = $clog2(HRES),
  localparam int VWIDTH      = $clog2(VRES),
  localparam int PMAX        = 2 ** DATA_WIDTH - 1,
  localparam int SUMW        = $clog2(K * K * PMAX + 1)
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic [HWIDTH-1:0]             hcount_in,
  input  logic [VWIDTH-1:0]             vcount_in,
  input  logic [DATA_WIDTH-1:0]         pixel_data_in,
  input  logic                          data_valid_in,
  input  logic [1:0]                    mode_in,
  input  logic [SUMW-1:0]               threshold_in,
  output logic                          pixel_data_out,
  output logic [SUMW-1:0]               sum_out,
  output logic [HWIDTH-KERNEL_LOG2-1:0] hcount_out,
  output logic [VWIDTH-KERNEL_LOG2-1:0] vcount_out,
  output logic                          data_valid_out,
  output logic                          frame_done_out
);

  localparam int NBINS = HRES / K;
  localparam int VBINS = VRES / K;
  localparam int BW    = HWIDTH - KERNEL_LOG2;
  localparam int VBW   = VWIDTH - KERNEL_LOG2;

  localparam logic [SUMW-1:0] FULL_SUM   = SUMW'(K * K * PMAX);
  localparam logic [SUMW-1:0] THRESH_RST = SUMW'(K * K * PMAX / 2);
  localparam logic [1:0]      MODE_ANY   = 2'd1;
  localparam logic [1:0]      MODE_ALL   = 2'd2;

  if (HRES % K != 0) begin : g_hres_check
    $error("binning_kxk: HRES must be a multiple of K");
  end
  if (VRES % K != 0) begin : g_vres_check
    $error("binning_kxk: VRES must be a multiple of K");
  end
  if (KERNEL_LOG2 < 1 || KERNEL_LOG2 > 4) begin : g_klog_check
    $error("binning_kxk: KERNEL_LOG2 must be in 1..4");
  end

  logic [KERNEL_LOG2-1:0] hsub;
  logic [KERNEL_LOG2-1:0] vsub;
  logic [BW-1:0]          bin;
  logic [VBW-1:0]         vbin;
  logic [SUMW-1:0]        pix;
  logic [SUMW-1:0]        rowsum;
  logic [SUMW-1:0]        binsum;
  logic                   row_end;
  logic                   emit;
  logic                   decision;

  logic [SUMW-1:0]        hacc_q, hacc_d;
  logic [SUMW-1:0]        acc_q [NBINS];
  logic                   armed_q;
  logic [1:0]             mode_q;
  logic [SUMW-1:0]        thresh_q;

  logic                   dv_q;
  logic                   pix_out_q;
  logic [SUMW-1:0]        sum_q;
  logic [BW-1:0]          hc_q;
  logic [VBW-1:0]         vc_q;
  logic                   fd_q;

  assign hsub    = hcount_in[KERNEL_LOG2-1:0];
  assign vsub    = vcount_in[KERNEL_LOG2-1:0];
  assign bin     = hcount_in[HWIDTH-1:KERNEL_LOG2];
  assign vbin    = vcount_in[VWIDTH-1:KERNEL_LOG2];
  assign pix     = SUMW'(pixel_data_in);
  assign rowsum  = hacc_q + pix;
  assign binsum  = acc_q[bin] + rowsum;
  assign row_end = &hsub;
  assign emit    = data_valid_in && row_end && (&vsub) && armed_q;
  assign hacc_d  = (hsub == '0) ? pix : rowsum;

  always_comb begin
    decision = 1'b0;
    case (mode_q)
      MODE_ANY: decision = (binsum != '0);
      MODE_ALL: decision = (binsum == FULL_SUM);
      default:  decision = (binsum > thresh_q);
    endcase
  end

  // The first row of a bin group overwrites, so no clearing pass is needed.
  always_ff @(posedge clk_in) begin
    if (data_valid_in && row_end) begin
      acc_q[bin] <= (vsub == '0) ? rowsum : acc_q[bin] + rowsum;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hacc_q    <= '0;
      armed_q   <= 1'b0;
      mode_q    <= '0;
      thresh_q  <= THRESH_RST;
      dv_q      <= 1'b0;
      pix_out_q <= 1'b0;
      sum_q     <= '0;
      hc_q      <= '0;
      vc_q      <= '0;
      fd_q      <= 1'b0;
    end else begin
      dv_q <= emit;
      fd_q <= emit && (bin == BW'(NBINS - 1)) && (vbin == VBW'(VBINS - 1));
      if (data_valid_in) begin
        hacc_q <= hacc_d;
        // Emission only starts once a clean row-group start has been seen.
        if (hcount_in == '0 && vsub == '0) begin
          armed_q <= 1'b1;
        end
        if (hcount_in == '0 && vcount_in == '0) begin
          mode_q   <= mode_in;
          thresh_q <= threshold_in;
        end
      end
      if (emit) begin
        pix_out_q <= decision;
        sum_q     <= binsum;
        hc_q      <= bin;
        vc_q      <= vbin;
      end
    end
  end

  assign data_valid_out = dv_q;
  assign pixel_data_out = pix_out_q;
  assign sum_out        = sum_q;
  assign hcount_out     = hc_q;
  assign vcount_out     = vc_q;
  assign frame_done_out = fd_q;

endmodule
